input_symbol_conditioner: RTL and testbench

Upstream front-end for the two-input pattern detector. Synchronises the raw i2/i1 pins, debounces them as one 2-bit symbol, and emits one symbol per accepted change. Emitted symbols are buffered in a small FIFO and presented to the detector over a valid/ready handshake, so the detector sees clean, single-event input steps.

---
 rtl/cond_pkg.sv | 16 +
 rtl/sym_fifo.sv | 72 +++++++
 rtl/input_symbol_conditioner.sv | 142 ++++++++++++++
 tb/tb_input_symbol_conditioner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared types for the input symbol conditioner: the 2-bit {i2, i1} symbol
// and the debounce FSM state encoding.
package cond_pkg;

  localparam int SYM_W = 2;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {
    DISABLED    = 2'd0,
    WAIT_CHANGE = 2'd1,
    SETTLING    = 2'd2,
    COMMIT      = 2'd3
  } cond_state_t;

endpackage

// File: rtl/sym_fifo.sv
// First-word-fall-through symbol FIFO. A push on a full FIFO is accepted only
// when a pop frees a slot in the same cycle; otherwise it is ignored here.
module sym_fifo
  import cond_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  sym_t             push_data,
  input  logic             pop,
  output sym_t             head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  sym_t             mem_q [DEPTH];
  sym_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Head reads as zero while empty so the outputs are clean after reset.
  assign head  = empty ? sym_t'(0) : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/input_symbol_conditioner.sv
// Synchronises and debounces the raw i2/i1 pins as one symbol, queues each
// accepted change and offers it downstream over valid/ready.
module input_symbol_conditioner
  import cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          raw_i2,
  input  logic                          raw_i1,
  input  logic                          enable,
  output logic                          sym_valid,
  input  logic                          sym_ready,
  output logic                          sym_i2,
  output logic                          sym_i1,
  output logic                          stable_i2,
  output logic                          stable_i1,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Handshake: a symbol transfers on any edge where sym_valid && sym_ready;
  // sym_valid never depends on sym_ready and the head holds until popped.

  sym_t        sync1_q, sync1_d;
  sym_t        sync2_q, sync2_d;
  sym_t        cand_q, cand_d;
  sym_t        stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cond_state_t state_q, state_d;
  logic        overflow_q, overflow_d;

  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  sym_t        fifo_head;
  sym_t        s;

  assign s       = sync2_q;
  assign sync1_d = {raw_i2, raw_i1};
  assign sync2_d = sync1_q;
  assign pop     = sym_ready && !fifo_empty;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    if (state_q == COMMIT) begin
      // Commit always finishes, even if enable drops this cycle.
      stable_d = cand_q;
      push     = 1'b1;
      state_d  = WAIT_CHANGE;
    end else if (!enable) begin
      state_d = DISABLED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DISABLED: begin
          cnt_d   = '0;
          state_d = WAIT_CHANGE;
        end
        WAIT_CHANGE: begin
          if (s != stable_q) begin
            cand_d  = s;
            cnt_d   = '0;
            state_d = SETTLING;
          end
        end
        SETTLING: begin
          if (s == cand_q) begin
            if (cnt_q == CNT_LAST) begin
              state_d = COMMIT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (s == stable_q) begin
            state_d = WAIT_CHANGE;
          end else begin
            cand_d = s;
            cnt_d  = '0;
          end
        end
        default: state_d = WAIT_CHANGE;
      endcase
    end
  end

  // A push the FIFO cannot take (full, no pop) is lost; remember it.
  assign overflow_d = overflow_q | (push && fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      state_q    <= WAIT_CHANGE;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (cand_q),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign sym_valid = !fifo_empty;
  assign sym_i2    = fifo_head[1];
  assign sym_i1    = fifo_head[0];
  assign stable_i2 = stable_q[1];
  assign stable_i1 = stable_q[0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_input_symbol_conditioner.sv
// Bench for input_symbol_conditioner: directed scenarios plus random pin
// activity, compared every cycle against a queue-based reference model.
module tb_input_symbol_conditioner;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_i2 = 1'b0;
  logic       raw_i1 = 1'b0;
  logic       enable = 1'b1;
  logic       sym_ready = 1'b0;
  logic       sym_valid;
  logic       sym_i2;
  logic       sym_i1;
  logic       stable_i2;
  logic       stable_i1;
  logic [2:0] fifo_level;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  input_symbol_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_i2     (raw_i2),
    .raw_i1     (raw_i1),
    .enable     (enable),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_i2     (sym_i2),
    .sym_i1     (sym_i1),
    .stable_i2  (stable_i2),
    .stable_i1  (stable_i1),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: pipeline of pin samples, a debounce "phase" tracked with
  // plain ints, and the emitted symbols held in an expected queue.
  logic [1:0] m_s1, m_s2, m_stable, m_cand;
  int         m_cnt, m_phase;   // 0 off, 1 idle, 2 settling, 3 commit
  logic       m_ovf;
  logic [1:0] exp_q[$];
  int         emitted;

  task automatic model_reset();
    m_s1 = 2'b00; m_s2 = 2'b00; m_stable = 2'b00; m_cand = 2'b00;
    m_cnt = 0; m_phase = 1; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic [1:0] s;
    logic       push;
    if (reset) begin
      model_reset();
      return;
    end
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = {raw_i2, raw_i1};
    push = 1'b0;
    if (m_phase == 3) begin
      m_stable = m_cand;
      push     = 1'b1;
      m_phase  = 1;
    end else if (!enable) begin
      m_phase = 0;
      m_cnt   = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (s != m_stable) begin
        m_cand = s; m_cnt = 0; m_phase = 2;
      end
    end else begin
      if (s == m_cand) begin
        if (m_cnt == D - 1) m_phase = 3;
        else m_cnt++;
      end else if (s == m_stable) begin
        m_phase = 1;
      end else begin
        m_cand = s; m_cnt = 0;
      end
    end
    if (exp_q.size() > 0 && sym_ready) void'(exp_q.pop_front());
    if (push) begin
      emitted++;
      if (exp_q.size() < DEPTH) exp_q.push_back(m_cand);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    logic [1:0] head;
    head = 2'b00;
    if (exp_q.size() > 0) head = exp_q[0];
    check("sym_valid", {7'd0, sym_valid}, {7'd0, exp_q.size() > 0});
    check("sym", {6'd0, sym_i2, sym_i1}, {6'd0, head});
    check("stable", {6'd0, stable_i2, stable_i1}, {6'd0, m_stable});
    check("fifo_level", {5'd0, fifo_level}, 8'(exp_q.size()));
    check("overflow", {7'd0, overflow}, {7'd0, m_ovf});
  endtask

  // driver: apply one cycle of inputs, advance the model on the edge, check
  task automatic cyc(input logic [1:0] raw, input logic en, input logic rdy, input logic rst);
    raw_i2    = raw[1];
    raw_i1    = raw[0];
    enable    = en;
    sym_ready = rdy;
    reset     = rst;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic hold(input logic [1:0] raw, input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(raw, 1'b1, rdy, 1'b0);
  endtask

  logic [1:0] pat [11] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11,
                           2'b10, 2'b00, 2'b10, 2'b11, 2'b01};
  int emitted_before;

  initial begin
    model_reset();
    emitted = 0;
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1, 1'b0, 1'b1);

    // clean step, then single-cycle pop
    hold(2'b00, 5, 1'b0);
    hold(2'b01, 12, 1'b0);
    hold(2'b01, 1, 1'b1);
    hold(2'b01, 3, 1'b0);

    // glitch back to the stable value is not emitted
    emitted_before = emitted;
    hold(2'b00, 2, 1'b0);
    hold(2'b01, 12, 1'b0);
    check("glitch_no_emit", 8'(emitted - emitted_before), 8'd0);

    // bounce through 10 before settling on 11
    emitted_before = emitted;
    hold(2'b10, 2, 1'b0);
    hold(2'b11, 12, 1'b0);
    check("bounce_one_emit", 8'(emitted - emitted_before), 8'd1);
    hold(2'b11, 4, 1'b1);

    // overflow: five changes with no consumer
    hold(2'b01, 10, 1'b0);
    hold(2'b11, 10, 1'b0);
    hold(2'b10, 10, 1'b0);
    hold(2'b00, 10, 1'b0);
    hold(2'b01, 10, 1'b0);
    check("ovf_sticky", {7'd0, overflow}, 8'd1);
    hold(2'b01, 6, 1'b1);

    // streaming detector pattern
    for (int p = 0; p < 11; p++) begin
      hold(pat[p], 8, 1'b1);
      check("stream_level", {7'd0, fifo_level > 3'd1}, 8'd0);
    end

    // enable low across a change, then release
    for (int i = 0; i < 8; i++) cyc(2'b00, 1'b0, 1'b1, 1'b0);
    hold(2'b00, 12, 1'b1);

    // reset while settling with two symbols queued
    hold(2'b10, 10, 1'b0);
    hold(2'b11, 10, 1'b0);
    hold(2'b00, 3, 1'b0);
    cyc(2'b00, 1'b1, 1'b0, 1'b1);
    check("rst_level", {5'd0, fifo_level}, 8'd0);
    emitted_before = emitted;
    hold(2'b00, 12, 1'b0);
    check("rst_no_emit", 8'(emitted - emitted_before), 8'd0);

    // random pin activity, consumer pressure, enable and reset
    for (int seg = 0; seg < 400; seg++) begin
      logic [1:0] r;
      logic       en;
      int         len, rdy_pct;
      r       = 2'($urandom_range(0, 3));
      en      = ($urandom_range(0, 9) != 0);
      len     = $urandom_range(1, 10);
      rdy_pct = $urandom_range(0, 100);
      if ($urandom_range(0, 59) == 0) cyc(r, en, 1'b0, 1'b1);
      for (int i = 0; i < len; i++)
        cyc(r, en, ($urandom_range(0, 99) < rdy_pct), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
